// File: rtl/accum_dump_decim_pkg.sv
// Shared definitions for the integrate-and-dump decimator: complex-split helpers
// and the decimation bound.
package accum_dump_decim_pkg;

  // Largest supported log2 decimation factor.
  localparam int unsigned MaxLogDecim = 8;

  // Width of one component (re or im) of a WDTH-bit complex sample.
  function automatic int unsigned half_width(input int unsigned w);
    return w / 2;
  endfunction

  // Real part occupies the upper half of the sample.
  function automatic int unsigned re_msb(input int unsigned w);
    return w - 1;
  endfunction

  function automatic int unsigned re_lsb(input int unsigned w);
    return w / 2;
  endfunction

  // Imaginary part occupies the lower half; its lsb is always bit 0.
  function automatic int unsigned im_msb(input int unsigned w);
    return w / 2 - 1;
  endfunction

endpackage

// File: rtl/accum_dump_decim_complex_accum.sv
// Single-component signed accumulator with load/add enables. dout is the
// arithmetically shifted value of the accumulator *including* this cycle's
// input, so the top level can capture the block average on the completing sample.
module accum_dump_decim_complex_accum
  import accum_dump_decim_pkg::*;
#(
  parameter int unsigned IW       = 16,
  parameter int unsigned LOGDECIM = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [IW-1:0] din,
  input  logic          load,
  input  logic          add,
  output logic [IW-1:0] dout
);

  // Growth of LOGDECIM bits makes overflow impossible over one block.
  localparam int unsigned AW = IW + LOGDECIM;

  logic signed [AW-1:0] ext;
  logic signed [AW-1:0] acc_q, acc_d;

  assign ext = AW'($signed(din));

  // Next accumulator value: load starts a block, add integrates into it.
  always_comb begin
    acc_d = acc_q;
    if (load) begin
      acc_d = ext;
    end else if (add) begin
      acc_d = acc_q + ext;
    end
  end

  // Accumulator register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  // Arithmetic shift floors toward minus infinity.
  assign dout = IW'(acc_d >>> LOGDECIM);

endmodule

// File: rtl/accum_dump_decim.sv
// Integrate-and-dump decimator for complex samples: averages each block of
// 2**LOGDECIM valid samples and emits one sample carrying the first sample's
// metadata. error is sticky and flags metadata changes inside a block.
module accum_dump_decim
  import accum_dump_decim_pkg::*;
#(
  parameter int unsigned WDTH     = 32,
  parameter int unsigned MWDTH    = 1,
  parameter int unsigned LOGDECIM = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WDTH-1:0]  in_data,
  input  logic             in_nd,
  input  logic [MWDTH-1:0] in_m,
  output logic [WDTH-1:0]  out_data,
  output logic             out_nd,
  output logic [MWDTH-1:0] out_m,
  output logic             error
);

  localparam int unsigned HalfW = half_width(WDTH);
  localparam int unsigned ReMsb = re_msb(WDTH);
  localparam int unsigned ReLsb = re_lsb(WDTH);
  localparam int unsigned ImMsb = im_msb(WDTH);
  localparam int unsigned Decim = 1 << LOGDECIM;
  // Keep the counter at least one bit wide; with LOGDECIM=0 it simply stays 0.
  localparam int unsigned CntW  = (LOGDECIM > 0) ? LOGDECIM : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(Decim - 1);

  if (LOGDECIM > MaxLogDecim) begin : gen_bad_logdecim
    $error("LOGDECIM out of range");
  end
  if ((WDTH % 2) != 0) begin : gen_bad_wdth
    $error("WDTH must be even");
  end

  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [MWDTH-1:0] m_cap_q, m_cap_d;
  logic             err_q, err_d;
  logic [WDTH-1:0]  out_data_q, out_data_d;
  logic             out_nd_q, out_nd_d;
  logic [MWDTH-1:0] out_m_q, out_m_d;

  logic             first, last;
  logic             acc_load, acc_add;
  logic [HalfW-1:0] avg_re, avg_im;

  assign first    = (cnt_q == '0);
  assign last     = (cnt_q == CntLast);
  assign acc_load = in_nd & first;
  assign acc_add  = in_nd & ~first;

  accum_dump_decim_complex_accum #(
    .IW       (HalfW),
    .LOGDECIM (LOGDECIM)
  ) u_acc_re (
    .clk  (clk),
    .rst  (rst),
    .din  (in_data[ReMsb:ReLsb]),
    .load (acc_load),
    .add  (acc_add),
    .dout (avg_re)
  );

  accum_dump_decim_complex_accum #(
    .IW       (HalfW),
    .LOGDECIM (LOGDECIM)
  ) u_acc_im (
    .clk  (clk),
    .rst  (rst),
    .din  (in_data[ImMsb:0]),
    .load (acc_load),
    .add  (acc_add),
    .dout (avg_im)
  );

  // Next state: count samples, capture/check metadata, dump on block completion.
  always_comb begin
    cnt_d      = cnt_q;
    m_cap_d    = m_cap_q;
    err_d      = err_q;
    out_data_d = out_data_q;
    out_nd_d   = 1'b0;
    out_m_d    = out_m_q;
    if (in_nd) begin
      cnt_d = last ? '0 : cnt_q + 1'b1;
      if (first) begin
        m_cap_d = in_m;
      end else if (in_m != m_cap_q) begin
        err_d = 1'b1;
      end
      if (last) begin
        out_nd_d   = 1'b1;
        out_data_d = {avg_re, avg_im};
        // With a single-sample block the capture register is not yet loaded.
        out_m_d    = first ? in_m : m_cap_q;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      m_cap_q    <= '0;
      err_q      <= 1'b0;
      out_data_q <= '0;
      out_nd_q   <= 1'b0;
      out_m_q    <= '0;
    end else begin
      cnt_q      <= cnt_d;
      m_cap_q    <= m_cap_d;
      err_q      <= err_d;
      out_data_q <= out_data_d;
      out_nd_q   <= out_nd_d;
      out_m_q    <= out_m_d;
    end
  end

  assign out_data = out_data_q;
  assign out_nd   = out_nd_q;
  assign out_m    = out_m_q;
  assign error    = err_q;

endmodule

// File: tb/tb_accum_dump_decim.sv
// Self-checking bench: a decimate-by-4 instance checked against a block-average
// model, plus a decimate-by-1 instance checked as a one-cycle delay.
module tb_accum_dump_decim;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // Decimate-by-4 instance.
  logic [31:0] in_data = '0;
  logic        in_nd   = 1'b0;
  logic [0:0]  in_m    = '0;
  logic [31:0] out_data;
  logic        out_nd;
  logic [0:0]  out_m;
  logic        error;

  // Decimate-by-1 instance.
  logic [31:0] d0_in_data = '0;
  logic        d0_in_nd   = 1'b0;
  logic [0:0]  d0_in_m    = '0;
  logic [31:0] d0_out_data;
  logic        d0_out_nd;
  logic [0:0]  d0_out_m;
  logic        d0_error;

  accum_dump_decim #(.WDTH(32), .MWDTH(1), .LOGDECIM(2)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_nd(in_nd), .in_m(in_m),
    .out_data(out_data), .out_nd(out_nd), .out_m(out_m), .error(error)
  );

  accum_dump_decim #(.WDTH(32), .MWDTH(1), .LOGDECIM(0)) dut0 (
    .clk(clk), .rst(rst), .in_data(d0_in_data), .in_nd(d0_in_nd), .in_m(d0_in_m),
    .out_data(d0_out_data), .out_nd(d0_out_nd), .out_m(d0_out_m), .error(d0_error)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: samples of the open block and expected outputs.
  int          blk_re[$];
  int          blk_im[$];
  logic        blk_m;
  logic [31:0] exp_data[$];
  logic        exp_m[$];
  logic [31:0] last_exp = '0;

  // Observed outputs of the decimate-by-4 instance.
  logic [31:0] got_data[$];
  logic        got_m[$];

  always @(negedge clk) begin
    if (out_nd === 1'b1) begin
      got_data.push_back(out_data);
      got_m.push_back(out_m[0]);
    end
  end

  function automatic int floor_div(input int a, input int d);
    int q;
    q = a / d;
    if ((a % d) != 0 && a < 0) q = q - 1;
    return q;
  endfunction

  // One clock of stimulus; returns 1 time unit after the capturing edge.
  task automatic cyc(input logic nd, input logic [15:0] re, input logic [15:0] im,
                     input logic m);
    in_nd   = nd;
    in_data = {re, im};
    in_m    = m;
    @(posedge clk);
    #1;
    in_nd = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 16'h0, 16'h0, 1'b0);
  endtask

  // Push one valid sample through the model and the DUT.
  task automatic send(input logic [15:0] re, input logic [15:0] im, input logic m);
    int sr, si;
    logic [31:0] e;
    blk_re.push_back(int'($signed(re)));
    blk_im.push_back(int'($signed(im)));
    if (blk_re.size() == 1) blk_m = m;
    if (blk_re.size() == 4) begin
      sr = 0;
      si = 0;
      foreach (blk_re[i]) begin
        sr += blk_re[i];
        si += blk_im[i];
      end
      e = {16'(floor_div(sr, 4)), 16'(floor_div(si, 4))};
      exp_data.push_back(e);
      exp_m.push_back(blk_m);
      last_exp = e;
      blk_re.delete();
      blk_im.delete();
    end
    cyc(1'b1, re, im, m);
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if ({out_data, out_nd, out_m, error} !== 35'h0)
      $display("FAIL reset_outputs: got %h expected 0", {out_data, out_nd, out_m, error});
    else n_pass++;
    n_checks++;
    if ({d0_out_data, d0_out_nd, d0_out_m, d0_error} !== 35'h0)
      $display("FAIL reset_outputs_d0: got %h expected 0",
               {d0_out_data, d0_out_nd, d0_out_m, d0_error});
    else n_pass++;
    idle(1);
    rst = 1'b0;
    idle(1);
  endtask

  task automatic test_basic();
    send(16'd1, -16'sd1, 1'b0);
    send(16'd2, -16'sd2, 1'b0);
    send(16'd3, -16'sd3, 1'b0);
    n_checks++;
    if (out_nd !== 1'b0) $display("FAIL basic_early_nd: got %b expected 0", out_nd);
    else n_pass++;
    send(16'd4, -16'sd4, 1'b0);
    n_checks++;
    if (out_nd !== 1'b1) $display("FAIL basic_latency_nd: got %b expected 1", out_nd);
    else n_pass++;
    n_checks++;
    if (out_data !== 32'h0002_FFFD)
      $display("FAIL basic_data: got %h expected 0002fffd", out_data);
    else n_pass++;
    idle(1);
    n_checks++;
    if (out_nd !== 1'b0) $display("FAIL basic_pulse_width: got %b expected 0", out_nd);
    else n_pass++;
    n_checks++;
    if (got_data.size() != exp_data.size() || got_data.size() != 1)
      $display("FAIL basic_count: got %0d expected %0d", got_data.size(), exp_data.size());
    else n_pass++;
    for (int i = 0; i < got_data.size() && i < exp_data.size(); i++) begin
      n_checks++;
      if (got_data[i] !== exp_data[i] || got_m[i] !== exp_m[i])
        $display("FAIL basic_out[%0d]: got %h/%b expected %h/%b", i, got_data[i], got_m[i],
                 exp_data[i], exp_m[i]);
      else n_pass++;
    end
    got_data.delete(); got_m.delete(); exp_data.delete(); exp_m.delete();
  endtask

  task automatic test_gaps();
    int gap;
    logic m;
    for (int b = 0; b < 4; b++) begin
      m = 1'($urandom);
      for (int s = 0; s < 4; s++) begin
        send(16'($urandom), 16'($urandom), m);
        gap = $urandom_range(0, 5);
        if (gap > 0) begin
          idle(1);
          n_checks++;
          if (out_nd !== 1'b0 || out_data !== last_exp)
            $display("FAIL gaps_hold: got %b/%h expected 0/%h", out_nd, out_data, last_exp);
          else n_pass++;
          idle(gap - 1);
        end
      end
    end
    idle(1);
    n_checks++;
    if (got_data.size() != exp_data.size())
      $display("FAIL gaps_count: got %0d expected %0d", got_data.size(), exp_data.size());
    else n_pass++;
    for (int i = 0; i < got_data.size() && i < exp_data.size(); i++) begin
      n_checks++;
      if (got_data[i] !== exp_data[i] || got_m[i] !== exp_m[i])
        $display("FAIL gaps_out[%0d]: got %h/%b expected %h/%b", i, got_data[i], got_m[i],
                 exp_data[i], exp_m[i]);
      else n_pass++;
    end
    got_data.delete(); got_m.delete(); exp_data.delete(); exp_m.delete();
  endtask

  task automatic test_back_to_back();
    for (int s = 0; s < 4; s++) send(16'($urandom), 16'($urandom), 1'b0);
    for (int s = 0; s < 4; s++) send(16'h7FFF, 16'h7FFF, 1'b0);
    idle(2);
    n_checks++;
    if (got_data.size() != 2 || exp_data.size() != 2)
      $display("FAIL b2b_count: got %0d expected 2", got_data.size());
    else n_pass++;
    n_checks++;
    if (exp_data.size() == 2 && exp_data[1] !== 32'h7FFF_7FFF)
      $display("FAIL b2b_model: got %h expected 7fff7fff", exp_data[1]);
    else n_pass++;
    for (int i = 0; i < got_data.size() && i < exp_data.size(); i++) begin
      n_checks++;
      if (got_data[i] !== exp_data[i] || got_m[i] !== exp_m[i])
        $display("FAIL b2b_out[%0d]: got %h/%b expected %h/%b", i, got_data[i], got_m[i],
                 exp_data[i], exp_m[i]);
      else n_pass++;
    end
    got_data.delete(); got_m.delete(); exp_data.delete(); exp_m.delete();
  endtask

  task automatic test_error();
    send(16'd10, 16'd20, 1'b1);
    send(16'd11, 16'd21, 1'b1);
    n_checks++;
    if (error !== 1'b0) $display("FAIL error_early: got %b expected 0", error);
    else n_pass++;
    send(16'd12, 16'd22, 1'b0);
    n_checks++;
    if (error !== 1'b1) $display("FAIL error_rise: got %b expected 1", error);
    else n_pass++;
    send(16'd13, 16'd23, 1'b1);
    for (int s = 0; s < 8; s++) send(16'($urandom), 16'($urandom), 1'b0);
    idle(1);
    n_checks++;
    if (error !== 1'b1) $display("FAIL error_sticky: got %b expected 1", error);
    else n_pass++;
    n_checks++;
    if (got_data.size() != exp_data.size())
      $display("FAIL error_count: got %0d expected %0d", got_data.size(), exp_data.size());
    else n_pass++;
    for (int i = 0; i < got_data.size() && i < exp_data.size(); i++) begin
      n_checks++;
      if (got_data[i] !== exp_data[i] || got_m[i] !== exp_m[i])
        $display("FAIL error_out[%0d]: got %h/%b expected %h/%b", i, got_data[i], got_m[i],
                 exp_data[i], exp_m[i]);
      else n_pass++;
    end
    got_data.delete(); got_m.delete(); exp_data.delete(); exp_m.delete();
  endtask

  task automatic test_mid_reset();
    send(16'h1234, 16'h4321, 1'b1);
    send(16'h5678, 16'h8765, 1'b1);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({out_data, out_nd, out_m, error} !== 35'h0)
      $display("FAIL midrst_outputs: got %h expected 0", {out_data, out_nd, out_m, error});
    else n_pass++;
    blk_re.delete();
    blk_im.delete();
    last_exp = '0;
    @(posedge clk);
    #1 rst = 1'b0;
    idle(1);
    for (int s = 0; s < 4; s++) send(16'($urandom), 16'($urandom), 1'b0);
    idle(2);
    n_checks++;
    if (got_data.size() != 1 || exp_data.size() != 1)
      $display("FAIL midrst_count: got %0d expected 1", got_data.size());
    else n_pass++;
    for (int i = 0; i < got_data.size() && i < exp_data.size(); i++) begin
      n_checks++;
      if (got_data[i] !== exp_data[i] || got_m[i] !== exp_m[i])
        $display("FAIL midrst_out[%0d]: got %h/%b expected %h/%b", i, got_data[i], got_m[i],
                 exp_data[i], exp_m[i]);
      else n_pass++;
    end
    got_data.delete(); got_m.delete(); exp_data.delete(); exp_m.delete();
  endtask

  task automatic test_decim1();
    logic [31:0] d, held;
    logic        m, nd;
    held = d0_out_data;
    for (int i = 0; i < 40; i++) begin
      nd = (i == 0) ? 1'b1 : 1'($urandom);
      d  = $urandom;
      m  = 1'($urandom);
      d0_in_nd   = nd;
      d0_in_data = d;
      d0_in_m    = m;
      @(posedge clk);
      #1;
      d0_in_nd = 1'b0;
      if (nd) held = d;
      n_checks++;
      if (d0_out_nd !== nd || d0_out_data !== held || (nd && d0_out_m[0] !== m))
        $display("FAIL decim1[%0d]: got %b/%h/%b expected %b/%h/%b", i, d0_out_nd,
                 d0_out_data, d0_out_m, nd, held, m);
      else n_pass++;
    end
    n_checks++;
    if (d0_error !== 1'b0) $display("FAIL decim1_error: got %b expected 0", d0_error);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_back_to_back();
    test_error();
    test_mid_reset();
    test_decim1();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/accum_dump_decim.md
Name: accum_dump_decim

Overview:
- Streaming integrate-and-dump decimator for complex samples; sits directly downstream of a pass-through/register stage in the sample chain and consumes its {data, nd, m} stream.
- Averages each block of 2**LOGDECIM consecutive valid samples and emits one averaged sample per block, carrying the first sample's metadata.
- No back-pressure; `in_nd` may be sparse, with arbitrary gaps.
- Flags metadata inconsistency within a block on `error`.

Parameters:
- WDTH, 32: total sample width. Real part in [WDTH-1:WDTH/2], imaginary in [WDTH/2-1:0]. Both halves are two's-complement signed. Must be even.
- MWDTH, 1: metadata width.
- LOGDECIM, 2: log2 of the decimation factor; DECIM = 2**LOGDECIM. Legal range 0..8.

Ports:
- clk  input  1  sole clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  WDTH  complex input sample {re, im}.
- in_nd  input  1  input sample valid, single-cycle qualifier.
- in_m  input  MWDTH  metadata accompanying in_data.
- out_data  output  WDTH  averaged complex sample {re, im}.
- out_nd  output  1  output valid, one-cycle pulse per block.
- out_m  output  MWDTH  metadata of first sample of the block.
- error  output  1  sticky error flag.

Interface decision: one clock; reset is asynchronous and active-high.

Behaviour:
- Reset, applied asynchronously, forces:
  - out_data=0, out_nd=0, out_m=0, error=0
  - sample counter cnt=0, accumulators acc_re=acc_im=0, captured metadata m_cap=0
- Reset asserted mid-block discards the partial block. No output is produced for it.
- State: cnt is a LOGDECIM-bit count of samples already absorbed in the current block.
- Cycles with in_nd=0: no state change, except out_nd is forced to 0.
- On in_nd=1 with cnt==0 (first sample of block):
  - acc_re/acc_im load the sign-extended input halves (load, not add).
  - m_cap <= in_m.
- On in_nd=1 with cnt!=0:
  - acc += sign-extended halves.
  - If in_m != m_cap, error <= 1.
- cnt increments on every in_nd and wraps from DECIM-1 to 0.
- Accumulator width is WDTH/2+LOGDECIM bits per component; it cannot overflow.
- Block completion is an in_nd with cnt==DECIM-1. On the next cycle:
  - out_nd=1 for exactly one cycle.
  - out_data={ (acc_re_final >>> LOGDECIM)[WDTH/2-1:0], (acc_im_final >>> LOGDECIM)[WDTH/2-1:0] }, using an arithmetic shift (floor toward minus infinity).
  - acc_*_final includes the completing sample.
  - out_m=m_cap. For DECIM==1, out_m=in_m of that sample.
- Latency: 1 cycle from the last in_nd of a block to out_nd.
- Back-to-back blocks: the first sample of the next block may arrive the cycle after completion, or in the same cycle as out_nd. Both are accepted; the accumulator reloads with no lost sample.
- out_data and out_m hold their last value while out_nd=0.
- LOGDECIM=0: behaves as a 1-cycle register of the input. Data is unchanged, error never set.
- error is sticky until rst. It never affects the data path.

Decomposition:
- Shared header (codebase defines file) holds:
  - the complex-split helpers: the re/im slice positions as functions of WDTH
  - the LOGDECIM upper-bound constant
- One natural sub-module, complex_accum: a single-component signed accumulator with load/add enable and a shifted output. Instantiate it twice, for re and im.
- Counter, metadata capture and error logic stay in the top level.

Test Plan:
- WDTH=32, LOGDECIM=2; four consecutive in_nd samples re=1,2,3,4, im=-1,-2,-3,-4 -> one out_nd one cycle after the 4th sample; out_data re=2 (10>>>2), im=-3 (-10>>>2 floors).
- Same config; samples with gaps of 0..5 idle cycles between them -> identical result; exactly one out_nd per 4 valid samples; out_data held otherwise.
- Two blocks back-to-back with no idle cycle; block 2 all re=im=0x7FFF -> second output re=im=0x7FFF; no overflow; first block unaffected.
- MWDTH=1; block in_m = 1,1,0,1 -> out_m=1 and error rises the cycle after the 3rd sample and stays high through the following clean blocks.
- Assert rst after 2 samples of a block, then release and send 4 new samples -> no output for the aborted block; outputs 0 during reset; next block averages only the new 4 samples.
- LOGDECIM=0; random in_data/in_m stream -> out_data/out_m equal the input delayed 1 cycle on every in_nd; error stays 0.
